mem_rd_arbiter: RTL and testbench

Two-requester arbiter that shares the single block-read port of main memory between the ICache and the DCache. It sits between both caches' `mem_*` read interfaces and the memory read bus. It captures one-cycle read pulses, serialises them one outstanding block read at a time, and routes the returned 128-bit block back to the requester that was granted.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_pick2.sv | 39 +++
 rtl/mem_rd_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_rd_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory block-read arbiter:
//   state_t        - arbiter FSM encoding (IDLE, ISSUE, WAIT)
//   REQ_I / REQ_D  - requester IDs, also used as indices into per-requester arrays
//   MEM_BLK_SIZE   - default block width in bits
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  localparam int MEM_BLK_SIZE = 128;

endpackage

// File: rtl/arb_pick2.sv
// arb_pick2
// Combinational two-way picker for the memory read arbiter.
// Ports:
//   pend   in  [1:0] pending flags, indexed by REQ_I / REQ_D
//   last   in        requester granted most recently
//   winner out       requester to grant (only meaningful when pend != 0)
// Build option: ARB_ROUND_ROBIN_EN selects round-robin on a tie (the side not
// granted last wins); otherwise the ICache wins every tie.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] pend,
  input  logic       last,
  output logic       winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = REQ_I;
    if (pend[REQ_I] && pend[REQ_D]) begin
      winner = ~last;
    end else if (pend[REQ_D]) begin
      winner = REQ_D;
    end
  end
`else
  // Fixed priority has no use for the history input.
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    winner = REQ_I;
    if (!pend[REQ_I] && pend[REQ_D]) begin
      winner = REQ_D;
    end
  end
`endif

endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter
// Shares the single memory block-read port between the ICache (I) and the
// DCache (D). One-cycle read pulses are captured into per-requester pending
// registers, served one outstanding block read at a time, and the returned
// block is routed to the granted requester.
// Ports:
//   cpu_clk, cpu_rst              clock, asynchronous active-high reset
//   ic_ren/ic_raddr               ICache read request (ren != 0 is a request)
//   ic_rrdy                       ICache request can be accepted
//   ic_rvalid/ic_rdata            ICache block return
//   dc_*                          same for the DCache
//   mem_rrdy                      memory can accept a read
//   mem_ren/mem_raddr             registered read command to memory
//   mem_rvalid/mem_rdata          memory block return
// Build option: ARB_ROUND_ROBIN_EN enables round-robin tie breaking with a
// last-grant pointer; without it the ICache wins every tie.
module mem_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BLK_SIZE = MEM_BLK_SIZE
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  input  logic [3:0]          ic_ren,
  input  logic [31:0]         ic_raddr,
  output logic                ic_rrdy,
  output logic                ic_rvalid,
  output logic [BLK_SIZE-1:0] ic_rdata,
  input  logic [3:0]          dc_ren,
  input  logic [31:0]         dc_raddr,
  output logic                dc_rrdy,
  output logic                dc_rvalid,
  output logic [BLK_SIZE-1:0] dc_rdata,
  input  logic                mem_rrdy,
  output logic [3:0]          mem_ren,
  output logic [31:0]         mem_raddr,
  input  logic                mem_rvalid,
  input  logic [BLK_SIZE-1:0] mem_rdata
);

  logic [3:0]  req_ren  [2];
  logic [31:0] req_addr [2];

  assign req_ren[REQ_I]  = ic_ren;
  assign req_ren[REQ_D]  = dc_ren;
  assign req_addr[REQ_I] = ic_raddr;
  assign req_addr[REQ_D] = dc_raddr;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic [1:0]  pend_q, pend_d;
  logic [3:0]  ren_q  [2];
  logic [3:0]  ren_d  [2];
  logic [31:0] addr_q [2];
  logic [31:0] addr_d [2];
  logic [3:0]  mem_ren_q, mem_ren_d;
  logic [31:0] mem_raddr_q, mem_raddr_d;
  logic        winner;
  logic        last_sel;
  logic        rsp_take;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign last_sel = last_q;
`else
  assign last_sel = REQ_D;
`endif

  arb_pick2 u_pick (
    .pend   (pend_q),
    .last   (last_sel),
    .winner (winner)
  );

  // A response only counts while a read is outstanding; anything else is dropped.
  assign rsp_take = mem_rvalid && (state_q == ST_WAIT);

  assign ic_rrdy   = ~pend_q[REQ_I];
  assign dc_rrdy   = ~pend_q[REQ_D];
  assign ic_rvalid = rsp_take && (gnt_q == REQ_I);
  assign dc_rvalid = rsp_take && (gnt_q == REQ_D);
  assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
  assign dc_rdata  = dc_rvalid ? mem_rdata : '0;
  assign mem_ren   = mem_ren_q;
  assign mem_raddr = mem_raddr_q;

  // Pending capture. The granted side has rrdy low, so its clear and a new
  // capture can never hit the same entry in one cycle.
  always_comb begin
    pend_d = pend_q;
    ren_d  = ren_q;
    addr_d = addr_q;
    if (rsp_take) begin
      pend_d[gnt_q] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if ((req_ren[i] != 4'd0) && !pend_q[i]) begin
        pend_d[i] = 1'b1;
        ren_d[i]  = req_ren[i];
        addr_d[i] = req_addr[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    mem_ren_d   = 4'd0;
    mem_raddr_d = mem_raddr_q;
    case (state_q)
      ST_IDLE: begin
        mem_raddr_d = 32'd0;
        if (|pend_q) begin
          gnt_d   = winner;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_rrdy) begin
          mem_ren_d   = ren_q[gnt_q];
          mem_raddr_d = addr_q[gnt_q];
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        mem_raddr_d = 32'd0;
      end
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d = last_q;
    if ((state_q == ST_IDLE) && (|pend_q)) begin
      last_d = winner;
    end
  end
`endif

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= REQ_I;
      pend_q      <= 2'b00;
      mem_ren_q   <= 4'd0;
      mem_raddr_q <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        ren_q[i]  <= 4'd0;
        addr_q[i] <= 32'd0;
      end
`ifdef ARB_ROUND_ROBIN_EN
      // Pointer starts at D so the first tie goes to I.
      last_q      <= REQ_D;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      pend_q      <= pend_d;
      mem_ren_q   <= mem_ren_d;
      mem_raddr_q <= mem_raddr_d;
      ren_q       <= ren_d;
      addr_q      <= addr_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter
// Directed bench for mem_rd_arbiter. Inputs change and outputs are checked
// on the falling clock edge; expected values are written out per step.
module tb_mem_rd_arbiter;
  import mem_arb_pkg::*;

  logic         cpu_clk = 1'b0;
  logic         cpu_rst;
  logic [3:0]   ic_ren, dc_ren;
  logic [31:0]  ic_raddr, dc_raddr;
  logic         ic_rrdy, dc_rrdy, ic_rvalid, dc_rvalid;
  logic [127:0] ic_rdata, dc_rdata;
  logic         mem_rrdy, mem_rvalid;
  logic [3:0]   mem_ren;
  logic [31:0]  mem_raddr;
  logic [127:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int prot_cnt = 0;

  always #5 cpu_clk = ~cpu_clk;

  mem_rd_arbiter dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .ic_ren     (ic_ren),
    .ic_raddr   (ic_raddr),
    .ic_rrdy    (ic_rrdy),
    .ic_rvalid  (ic_rvalid),
    .ic_rdata   (ic_rdata),
    .dc_ren     (dc_ren),
    .dc_raddr   (dc_raddr),
    .dc_rrdy    (dc_rrdy),
    .dc_rvalid  (dc_rvalid),
    .dc_rdata   (dc_rdata),
    .mem_rrdy   (mem_rrdy),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  // Requests presented while rrdy is low violate the protocol; count them.
  always @(posedge cpu_clk) begin
    if (!cpu_rst && (((ic_ren != 4'd0) && !ic_rrdy) || ((dc_ren != 4'd0) && !dc_rrdy))) begin
      prot_cnt++;
      $display("note: protocol violation, request while rrdy low (t=%0t)", $time);
    end
  end

  task automatic nxt();
    @(negedge cpu_clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the read pulse, check it, answer after dly extra cycles, and
  // check routing of the returned block.
  task automatic expect_read(input string tag, input logic side, input logic [31:0] a,
                             input logic [3:0] r, input logic [127:0] d,
                             input int exp_n, input int dly);
    int n = 0;
    while (mem_ren == 4'd0 && n < 20) begin
      nxt();
      n++;
    end
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_ren"}, mem_ren, r);
    chk({tag, "_raddr"}, mem_raddr, a);
    nxt();
    chk({tag, "_ren_pulse"}, mem_ren, 4'd0);
    chk({tag, "_raddr_hold"}, mem_raddr, a);
    repeat (dly) nxt();
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    #1;
    chk({tag, "_ic_rvalid"}, ic_rvalid, side == REQ_I);
    chk({tag, "_dc_rvalid"}, dc_rvalid, side == REQ_D);
    chk({tag, "_rdata"}, (side == REQ_I) ? ic_rdata : dc_rdata, d);
    chk({tag, "_rdata_other"}, (side == REQ_I) ? dc_rdata : ic_rdata, 128'd0);
    nxt();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    $display("txn %s: side=%0d addr=%0h ren=%0h latency=%0d", tag, side, a, r, n);
  endtask

  initial begin
    cpu_rst = 1'b1; ic_ren = 0; dc_ren = 0; ic_raddr = 0; dc_raddr = 0;
    mem_rrdy = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    nxt(); nxt();
    chk("rst_ic_rrdy", ic_rrdy, 1'b1);
    chk("rst_dc_rrdy", dc_rrdy, 1'b1);
    chk("rst_ic_rvalid", ic_rvalid, 1'b0);
    chk("rst_dc_rvalid", dc_rvalid, 1'b0);
    chk("rst_mem_ren", mem_ren, 4'd0);
    chk("rst_mem_raddr", mem_raddr, 32'd0);
    cpu_rst = 1'b0;
    nxt();

    // 1: single ICache read, memory answers 3 cycles after the pulse
    ic_ren = 4'hF; ic_raddr = 32'h0000_1230;
    nxt();
    ic_ren = 4'h0;
    chk("t1_ic_rrdy_low", ic_rrdy, 1'b0);
    chk("t1_dc_rrdy", dc_rrdy, 1'b1);
    expect_read("t1", REQ_I, 32'h1230, 4'hF, 128'hA1A1_0000_1111_2222_3333_4444_5555_6666, 2, 2);
    chk("t1_ic_rrdy_back", ic_rrdy, 1'b1);
    nxt();
    chk("t1_raddr_idle", mem_raddr, 32'd0);

    // 2: simultaneous requests, I wins the first tie in both builds
    ic_ren = 4'hF; ic_raddr = 32'h100; dc_ren = 4'h3; dc_raddr = 32'h200;
    nxt();
    ic_ren = 0; dc_ren = 0;
    expect_read("t2_first", REQ_I, 32'h100, 4'hF, 128'h1001, 2, 0);
    expect_read("t2_second", REQ_D, 32'h200, 4'h3, 128'h2002, 2, 0);

    // 2b: after a lone I grant, a tie separates the two builds
    ic_ren = 4'h1; ic_raddr = 32'h110;
    nxt();
    ic_ren = 0;
    expect_read("t2b_solo", REQ_I, 32'h110, 4'h1, 128'h1101, 2, 0);
    ic_ren = 4'h2; ic_raddr = 32'h120; dc_ren = 4'h4; dc_raddr = 32'h220;
    nxt();
    ic_ren = 0; dc_ren = 0;
`ifdef ARB_ROUND_ROBIN_EN
    expect_read("t2b_tie", REQ_D, 32'h220, 4'h4, 128'h2202, 2, 0);
    expect_read("t2b_rest", REQ_I, 32'h120, 4'h2, 128'h1202, 2, 0);
`else
    expect_read("t2b_tie", REQ_I, 32'h120, 4'h2, 128'h1202, 2, 0);
    expect_read("t2b_rest", REQ_D, 32'h220, 4'h4, 128'h2202, 2, 0);
`endif

    // 3: backpressure, mem_rrdy low for 5 cycles while in ISSUE
    mem_rrdy = 1'b0;
    ic_ren = 4'h7; ic_raddr = 32'h300;
    nxt();
    ic_ren = 0;
    for (int k = 0; k < 5; k++) begin
      chk("t3_ren_held", mem_ren, 4'd0);
      chk("t3_ic_rrdy_low", ic_rrdy, 1'b0);
      nxt();
    end
    mem_rrdy = 1'b1;
    expect_read("t3", REQ_I, 32'h300, 4'h7, 128'h3003, 1, 0);

    // 4: DCache request lands in the same cycle as the I return
    ic_ren = 4'hF; ic_raddr = 32'h380;
    nxt();
    ic_ren = 0;
    nxt(); nxt();
    chk("t4_ic_pulse", mem_ren, 4'hF);
    nxt();
    chk("t4_wait_dc_rrdy", dc_rrdy, 1'b1);
    dc_ren = 4'h5; dc_raddr = 32'h400;
    mem_rvalid = 1'b1; mem_rdata = 128'h3803;
    #1;
    chk("t4_ic_rvalid", ic_rvalid, 1'b1);
    chk("t4_dc_rvalid", dc_rvalid, 1'b0);
    nxt();
    dc_ren = 0; mem_rvalid = 1'b0; mem_rdata = '0;
    chk("t4_dc_captured", dc_rrdy, 1'b0);
    expect_read("t4_dc", REQ_D, 32'h400, 4'h5, 128'h4004, 2, 0);

    // 5: reset asserted mid-WAIT, late response must be discarded
    ic_ren = 4'hF; ic_raddr = 32'h500;
    nxt();
    ic_ren = 0;
    nxt(); nxt();
    chk("t5_pulse", mem_ren, 4'hF);
    nxt();
    cpu_rst = 1'b1;
    #1;
    chk("t5_rst_ic_rrdy", ic_rrdy, 1'b1);
    chk("t5_rst_dc_rrdy", dc_rrdy, 1'b1);
    chk("t5_rst_mem_ren", mem_ren, 4'd0);
    chk("t5_rst_raddr", mem_raddr, 32'd0);
    nxt();
    cpu_rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 128'h5005;
    #1;
    chk("t5_late_ic_rvalid", ic_rvalid, 1'b0);
    chk("t5_late_dc_rvalid", dc_rvalid, 1'b0);
    chk("t5_late_ic_rdata", ic_rdata, 128'd0);
    nxt();
    mem_rvalid = 1'b0; mem_rdata = '0;
    nxt(); nxt();
    chk("t5_idle_mem_ren", mem_ren, 4'd0);
    chk("t5_idle_ic_rrdy", ic_rrdy, 1'b1);
    $display("txn t5: reset mid-WAIT, late rvalid dropped");

    // 6: illegal re-request while rrdy is low is ignored
    ic_ren = 4'hF; ic_raddr = 32'h600;
    nxt();
    ic_raddr = 32'h6F0;
    nxt();
    ic_ren = 0;
    expect_read("t6", REQ_I, 32'h600, 4'hF, 128'h6006, 1, 0);
    for (int k = 0; k < 5; k++) begin
      chk("t6_no_second_ren", mem_ren, 4'd0);
      nxt();
    end
    chk("t6_ic_rrdy", ic_rrdy, 1'b1);
    chk("t6_prot_flagged", prot_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
